// File: rtl/ro_sensor_pkg.sv
// Shared defaults and averaging FSM encoding for the ring-oscillator sensor monitor.
package ro_sensor_pkg;
  localparam int unsigned WIDTH_DEF      = 64;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned AVG_LOG2_DEF   = 3;
  localparam int unsigned ALARM_HITS_DEF = 2;

  typedef logic [1:0] avg_state_t;
  localparam avg_state_t ST_IDLE    = 2'd0;
  localparam avg_state_t ST_ACCUM   = 2'd1;
  localparam avg_state_t ST_PUBLISH = 2'd2;
endpackage

// File: rtl/ro_sensor_monitor_if.sv
// Sample input and FIFO output stream of the monitor; master is the monitor side.
interface ro_sensor_monitor_if #(
  parameter int unsigned width_size = ro_sensor_pkg::WIDTH_DEF
);
  logic [width_size-1:0] ro_meas_count;
  logic                  sample_valid;
  logic [width_size-1:0] out_count;
  logic                  out_valid;
  logic                  out_ready;

  modport master (input ro_meas_count, sample_valid, out_ready, output out_count, out_valid);
  modport slave  (output ro_meas_count, sample_valid, out_ready, input out_count, out_valid);
endinterface

// File: rtl/ro_sample_fifo.sv
// Power-of-two sample FIFO; head visible one cycle after push, reads zero when empty.
// Push while full is refused unless a pop happens in the same cycle; flush empties it.
module ro_sample_fifo #(
  parameter int unsigned width = 64,
  parameter int unsigned depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [width-1:0] push_dat,
  input  logic             pop,
  output logic [width-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int unsigned aw = $clog2(depth);
  localparam logic [aw:0] cnt_full = (aw + 1)'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr, rd_ptr;
  logic [aw:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == cnt_full);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + aw'(1);
      if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
      count <= count + {{aw{1'b0}}, do_push} - {{aw{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/ro_sensor_monitor.sv
// RO sensor monitor: min/max/windowed average, range alarm and a sample FIFO.
// Stats update one cycle after an accepted sample; a full FIFO drops samples and flags overflow.
module ro_sensor_monitor #(
  parameter int unsigned width_size = ro_sensor_pkg::WIDTH_DEF,
  parameter int unsigned fifo_depth = ro_sensor_pkg::FIFO_DEPTH_DEF,
  parameter int unsigned avg_log2   = ro_sensor_pkg::AVG_LOG2_DEF,
  parameter int unsigned alarm_hits = ro_sensor_pkg::ALARM_HITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  ro_sensor_monitor_if.master   mon,
  input  logic                  clear,
  input  logic [width_size-1:0] th_low,
  input  logic [width_size-1:0] th_high,
  input  logic                  alarm_en,
  output logic [width_size-1:0] min_count,
  output logic [width_size-1:0] max_count,
  output logic [width_size-1:0] avg_count,
  output logic                  avg_valid,
  output logic                  alarm,
  output logic                  alarm_sticky,
  output logic                  overflow,
  output logic [31:0]           sample_total
);
  import ro_sensor_pkg::*;

  localparam int unsigned sum_w = width_size + avg_log2;
  localparam int unsigned cnt_w = avg_log2 + 1;
  localparam int unsigned hit_w = $clog2(alarm_hits + 1);
  localparam logic [cnt_w-1:0] win_last = cnt_w'(1 << avg_log2);
  localparam logic [hit_w-1:0] hit_max  = hit_w'(alarm_hits);

  avg_state_t            state;
  logic [sum_w-1:0]      sum, next_sum;
  logic [cnt_w-1:0]      win_cnt, next_cnt;
  logic [hit_w-1:0]      hit_cnt, next_hit;
  logic [width_size-1:0] sample, fifo_head;
  logic                  accept, out_of_range, fifo_full, fifo_empty, fifo_pop;

  assign sample       = mon.ro_meas_count;
  assign accept       = mon.sample_valid && !clear;
  assign out_of_range = (sample < th_low) || (sample > th_high);
  assign fifo_pop     = !fifo_empty && mon.out_ready;
  assign mon.out_valid = !fifo_empty;
  assign mon.out_count = fifo_head;
  assign avg_valid    = (state == ST_PUBLISH);

  // Outside ACCUM an accepted sample always opens a fresh window.
  always_comb begin
    next_sum = sum_w'(sample);
    next_cnt = cnt_w'(1);
    if (state == ST_ACCUM) begin
      next_sum = sum + sum_w'(sample);
      next_cnt = win_cnt + cnt_w'(1);
    end
  end

  always_comb begin
    next_hit = hit_cnt;
    if (!alarm_en) begin
      next_hit = '0;
    end else if (accept) begin
      if (!out_of_range)         next_hit = '0;
      else if (hit_cnt != hit_max) next_hit = hit_cnt + hit_w'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sum          <= '0;
      win_cnt      <= '0;
      hit_cnt      <= '0;
      min_count    <= '1;
      max_count    <= '0;
      avg_count    <= '0;
      alarm        <= 1'b0;
      alarm_sticky <= 1'b0;
      overflow     <= 1'b0;
      sample_total <= '0;
    end else if (clear) begin
      state        <= ST_IDLE;
      sum          <= '0;
      win_cnt      <= '0;
      hit_cnt      <= '0;
      min_count    <= '1;
      max_count    <= '0;
      avg_count    <= '0;
      alarm        <= 1'b0;
      alarm_sticky <= 1'b0;
      overflow     <= 1'b0;
      sample_total <= '0;
    end else begin
      hit_cnt <= next_hit;
      alarm   <= (next_hit >= hit_max);
      if (next_hit >= hit_max) alarm_sticky <= 1'b1;
      if (accept && fifo_full && !fifo_pop) overflow <= 1'b1;
      if (accept) begin
        sample_total <= sample_total + 32'd1;
        if (sample < min_count) min_count <= sample;
        if (sample > max_count) max_count <= sample;
        sum     <= next_sum;
        win_cnt <= next_cnt;
        if (next_cnt == win_last) begin
          state     <= ST_PUBLISH;
          avg_count <= width_size'(next_sum >> avg_log2);
        end else begin
          state <= ST_ACCUM;
        end
      end else if (state == ST_PUBLISH) begin
        state <= ST_IDLE;
      end
    end
  end

  ro_sample_fifo #(.width(width_size), .depth(fifo_depth)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .push     (accept),
    .push_dat (sample),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
endmodule
